id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core; sits directly upstream of the ALU.
- Registers decoded instruction fields and control bits.
- Resolves operand forwarding from EX/MEM and MEM/WB; drives ALU data1/data2/ALUCtrl.
- Detects load-use hazards, stalls IF/ID and inserts a bubble.

---
 rtl/id_ex_operand_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register with operand forwarding and
//                load-use hazard detection, feeding the ALU.
//                Optional macro ID_EX_WB_BYPASS_EN: capture MEM/WB data at
//                ID/EX load for register files without write-before-read.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic            id_uses_rs2_i,
    input  logic [2:0]      id_alu_ctrl_i,
    input  logic            id_alu_src_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            id_mem_to_reg_i,
    input  logic            flush_i,
    input  logic            mem_stall_i,
    input  logic            exmem_reg_write_i,
    input  logic [RA_W-1:0] exmem_rd_addr_i,
    input  logic [XLEN-1:0] exmem_data_i,
    input  logic            memwb_reg_write_i,
    input  logic [RA_W-1:0] memwb_rd_addr_i,
    input  logic [XLEN-1:0] memwb_data_i,
    output logic [XLEN-1:0] alu_data1_o,
    output logic [XLEN-1:0] alu_data2_o,
    output logic [2:0]      alu_ctrl_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [RA_W-1:0] ex_rd_addr_o,
    output logic            ex_valid_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            load_use_stall_o
);

    localparam logic [RA_W-1:0] c_x0 = '0;

    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rs1_addr;
    logic [RA_W-1:0] r_rs2_addr;
    logic [RA_W-1:0] r_rd_addr;
    logic [2:0]      r_alu_ctrl;
    logic            r_alu_src;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_mem_to_reg;

    logic            w_exmem_hit1;
    logic            w_exmem_hit2;
    logic            w_memwb_hit1;
    logic            w_memwb_hit2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_cap_rs1;
    logic [XLEN-1:0] w_cap_rs2;
    logic            w_load_use;
    logic            w_clear;

    // Forwarding matches on the registered source addresses; x0 never matches.
    assign w_exmem_hit1 = exmem_reg_write_i && (exmem_rd_addr_i != c_x0) &&
                          (exmem_rd_addr_i == r_rs1_addr);
    assign w_exmem_hit2 = exmem_reg_write_i && (exmem_rd_addr_i != c_x0) &&
                          (exmem_rd_addr_i == r_rs2_addr);
    assign w_memwb_hit1 = memwb_reg_write_i && (memwb_rd_addr_i != c_x0) &&
                          (memwb_rd_addr_i == r_rs1_addr);
    assign w_memwb_hit2 = memwb_reg_write_i && (memwb_rd_addr_i != c_x0) &&
                          (memwb_rd_addr_i == r_rs2_addr);

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (w_exmem_hit1)
            w_fwd_rs1 = exmem_data_i;
        else if (w_memwb_hit1)
            w_fwd_rs1 = memwb_data_i;

        w_fwd_rs2 = r_rs2_data;
        if (w_exmem_hit2)
            w_fwd_rs2 = exmem_data_i;
        else if (w_memwb_hit2)
            w_fwd_rs2 = memwb_data_i;
    end

`ifdef ID_EX_WB_BYPASS_EN
    assign w_cap_rs1 = (memwb_reg_write_i && (memwb_rd_addr_i != c_x0) &&
                        (memwb_rd_addr_i == id_rs1_addr_i)) ? memwb_data_i : id_rs1_data_i;
    assign w_cap_rs2 = (memwb_reg_write_i && (memwb_rd_addr_i != c_x0) &&
                        (memwb_rd_addr_i == id_rs2_addr_i)) ? memwb_data_i : id_rs2_data_i;
`else
    assign w_cap_rs1 = id_rs1_data_i;
    assign w_cap_rs2 = id_rs2_data_i;
`endif

    assign w_load_use = id_valid_i && r_valid && r_mem_read && (r_rd_addr != c_x0) &&
                        ((r_rd_addr == id_rs1_addr_i) ||
                         (id_uses_rs2_i && (r_rd_addr == id_rs2_addr_i))) &&
                        !flush_i && !mem_stall_i;

    // Load-use is already suppressed under flush/stall, so one clear term keeps priority.
    assign w_clear = rst_i || flush_i || w_load_use;

    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_valid      <= 1'b0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1_addr   <= '0;
            r_rs2_addr   <= '0;
            r_rd_addr    <= '0;
            r_alu_ctrl   <= 3'b000;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (mem_stall_i) begin
            // Refresh operands so a value retiring from MEM/WB during the stall survives.
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end else begin
            r_valid      <= id_valid_i;
            r_rs1_data   <= w_cap_rs1;
            r_rs2_data   <= w_cap_rs2;
            r_imm        <= id_imm_i;
            r_rs1_addr   <= id_rs1_addr_i;
            r_rs2_addr   <= id_rs2_addr_i;
            r_rd_addr    <= id_rd_addr_i;
            r_alu_ctrl   <= id_alu_ctrl_i;
            r_alu_src    <= id_alu_src_i;
            r_reg_write  <= id_reg_write_i;
            r_mem_read   <= id_mem_read_i;
            r_mem_write  <= id_mem_write_i;
            r_mem_to_reg <= id_mem_to_reg_i;
        end
    end

    assign alu_data1_o      = w_fwd_rs1;
    assign alu_data2_o      = r_alu_src ? r_imm : w_fwd_rs2;
    assign alu_ctrl_o       = r_alu_ctrl;
    assign ex_store_data_o  = w_fwd_rs2;
    assign ex_rd_addr_o     = r_rd_addr;
    assign ex_valid_o       = r_valid;
    assign ex_reg_write_o   = r_reg_write;
    assign ex_mem_read_o    = r_mem_read;
    assign ex_mem_write_o   = r_mem_write;
    assign ex_mem_to_reg_o  = r_mem_to_reg;
    assign load_use_stall_o = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Directed scoreboard bench for id_ex_operand_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    localparam int F_D1 = 0, F_D2 = 1, F_ST = 2, F_CTRL = 3, F_RD = 4, F_VALID = 5;
    localparam int F_RW = 6, F_MR = 7, F_MW = 8, F_M2R = 9, F_STALL = 10;

    typedef struct {
        int          cyc;
        int          f;
        logic [31:0] v;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_uses_rs2;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        flush, mem_stall;
    logic        exmem_rw, memwb_rw;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] alu_data1, alu_data2, store_data;
    logic [2:0]  alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, lu_stall;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr), .id_rd_addr_i(id_rd_addr),
        .id_uses_rs2_i(id_uses_rs2), .id_alu_ctrl_i(id_alu_ctrl), .id_alu_src_i(id_alu_src),
        .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .id_mem_write_i(id_mem_write), .id_mem_to_reg_i(id_mem_to_reg),
        .flush_i(flush), .mem_stall_i(mem_stall),
        .exmem_reg_write_i(exmem_rw), .exmem_rd_addr_i(exmem_rd), .exmem_data_i(exmem_data),
        .memwb_reg_write_i(memwb_rw), .memwb_rd_addr_i(memwb_rd), .memwb_data_i(memwb_data),
        .alu_data1_o(alu_data1), .alu_data2_o(alu_data2), .alu_ctrl_o(alu_ctrl),
        .ex_store_data_o(store_data), .ex_rd_addr_o(ex_rd), .ex_valid_o(ex_valid),
        .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
        .ex_mem_to_reg_o(ex_m2r), .load_use_stall_o(lu_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sel(input int f);
        case (f)
            F_D1:    return alu_data1;
            F_D2:    return alu_data2;
            F_ST:    return store_data;
            F_CTRL:  return {29'd0, alu_ctrl};
            F_RD:    return {27'd0, ex_rd};
            F_VALID: return {31'd0, ex_valid};
            F_RW:    return {31'd0, ex_rw};
            F_MR:    return {31'd0, ex_mr};
            F_MW:    return {31'd0, ex_mw};
            F_M2R:   return {31'd0, ex_m2r};
            default: return {31'd0, lu_stall};
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle, away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = sel(e.f);
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.v);
            end
        end
    end

    task automatic expect_now(input int f, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc; e.f = f; e.v = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic u2, input logic [2:0] ctrl,
                          input logic src, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
        id_valid = v; id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_uses_rs2 = u2;
        id_alu_ctrl = ctrl; id_alu_src = src; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic id_idle();
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    endtask

    task automatic fwd_set(input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                           input logic mrw, input logic [4:0] mrd, input logic [31:0] md);
        exmem_rw = erw; exmem_rd = erd; exmem_data = ed;
        memwb_rw = mrw; memwb_rd = mrd; memwb_data = md;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        id_idle();
        fwd_set(0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset mid-stream: load a real instruction, then reset while ID stays valid
        id_set(1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 1, 3'b101, 0, 1, 0, 1, 1);
        tick();
        expect_now(F_VALID, 1, "load_valid");
        expect_now(F_CTRL, 3'b101, "load_ctrl");
        expect_now(F_RD, 3, "load_rd");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = F_D1; f <= F_STALL; f++) expect_now(f, 0, $sformatf("reset_field%0d", f));
        id_idle();
        tick();

        // Consumer rs1=x3, rs2=x4, immediate operand 2
        id_set(1, 3, 4, 6, 32'hAAAA, 32'h44, 32'h123, 1, 3'b010, 1, 1, 0, 0, 0);
        tick();
        fwd_set(1, 3, 32'h10, 1, 3, 32'h5);
        expect_now(F_D1, 32'h10, "exmem_priority_d1");
        expect_now(F_D2, 32'h123, "imm_operand2");
        expect_now(F_ST, 32'h44, "store_unforwarded");
        tick();
        fwd_set(0, 3, 32'h10, 1, 3, 32'h5);
        expect_now(F_D1, 32'h5, "memwb_fwd_d1");
        tick();
        fwd_set(0, 0, 0, 1, 4, 32'h66);
        expect_now(F_D1, 32'hAAAA, "no_fwd_d1");
        expect_now(F_ST, 32'h66, "memwb_fwd_store");
        tick();
        fwd_set(1, 4, 32'h77, 1, 4, 32'h66);
        expect_now(F_ST, 32'h77, "exmem_priority_store");
        expect_now(F_D2, 32'h123, "imm_ignores_fwd");
        id_idle();
        tick();

        // x0 guard: forwarding sources name x0
        id_set(1, 0, 0, 7, 0, 0, 0, 1, 3'b000, 0, 1, 0, 0, 0);
        tick();
        fwd_set(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        expect_now(F_D1, 0, "x0_no_fwd_d1");
        expect_now(F_D2, 0, "x0_no_fwd_d2");
        fwd_set(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        id_set(1, 1, 0, 0, 32'h100, 0, 4, 0, 3'b000, 1, 1, 1, 0, 1);  // lw x0
        tick();
        fwd_set(0, 0, 0, 0, 0, 0);
        id_set(1, 0, 0, 6, 0, 0, 0, 1, 3'b000, 0, 1, 0, 0, 0);
        expect_now(F_MR, 1, "lw_x0_in_ex");
        expect_now(F_STALL, 0, "lw_x0_no_stall");
        tick();

        // Load-use: lw x5 then add x6,x5,x7
        id_set(1, 1, 0, 5, 32'h100, 0, 4, 0, 3'b000, 1, 1, 1, 0, 1);
        tick();
        id_set(1, 5, 7, 6, 32'hBAD, 32'h7, 0, 1, 3'b000, 0, 1, 0, 0, 0);
        expect_now(F_STALL, 1, "load_use_stall");
        tick();
        expect_now(F_VALID, 0, "bubble_valid");
        expect_now(F_RW, 0, "bubble_rw");
        expect_now(F_MR, 0, "bubble_mr");
        expect_now(F_STALL, 0, "bubble_masks_stall");
        tick();
        fwd_set(0, 0, 0, 1, 5, 32'h55);
        id_idle();
        expect_now(F_VALID, 1, "add_after_bubble");
        expect_now(F_D1, 32'h55, "add_memwb_x5");
        expect_now(F_D2, 32'h7, "add_rs2");
        expect_now(F_RD, 6, "add_rd");
        tick();
        fwd_set(0, 0, 0, 0, 0, 0);

        // Flush suppresses the load-use stall and loads a bubble
        id_set(1, 1, 0, 5, 32'h100, 0, 4, 0, 3'b000, 1, 1, 1, 0, 1);
        tick();
        id_set(1, 5, 7, 6, 32'hBAD, 32'h7, 0, 1, 3'b000, 0, 1, 0, 0, 0);
        flush = 1'b1;
        expect_now(F_STALL, 0, "flush_blocks_stall");
        tick();
        flush = 1'b0;
        id_idle();
        expect_now(F_VALID, 0, "flush_bubble");
        tick();

        // rs2 only counts when the instruction uses it
        id_set(1, 1, 0, 5, 32'h100, 0, 4, 0, 3'b000, 1, 1, 1, 0, 1);
        tick();
        id_set(1, 9, 5, 6, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0);
        expect_now(F_STALL, 0, "rs2_unused_no_stall");
        tick();

        // Memory stall for three cycles while MEM/WB retires x8
        id_set(1, 8, 0, 10, 32'h11, 0, 0, 0, 3'b011, 0, 1, 0, 0, 0);
        tick();
        id_set(1, 1, 2, 11, 32'h1, 32'h2, 0, 1, 3'b111, 0, 1, 0, 0, 0);
        mem_stall = 1'b1;
        fwd_set(0, 0, 0, 1, 8, 32'h77);
        expect_now(F_D1, 32'h77, "stall_live_fwd");
        tick();
        fwd_set(0, 0, 0, 0, 0, 0);
        expect_now(F_D1, 32'h77, "stall_refreshed_d1");
        expect_now(F_CTRL, 3'b011, "stall_holds_ctrl");
        tick();
        tick();
        mem_stall = 1'b0;
        expect_now(F_D1, 32'h77, "release_d1");
        expect_now(F_VALID, 1, "release_valid");
        expect_now(F_RD, 10, "release_rd");
        tick();
        expect_now(F_CTRL, 3'b111, "next_instr_loaded");

        // Concurrent flush and memory stall: flush wins
        flush = 1'b1;
        mem_stall = 1'b1;
        tick();
        flush = 1'b0;
        mem_stall = 1'b0;
        id_idle();
        expect_now(F_VALID, 0, "flush_over_stall_valid");
        expect_now(F_CTRL, 0, "flush_over_stall_ctrl");
        expect_now(F_RW, 0, "flush_over_stall_rw");
        tick();

        // Same-cycle write-back at ID/EX load
        id_set(1, 9, 0, 1, 32'h1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0);
        fwd_set(0, 0, 0, 1, 9, 32'h99);
        tick();
        fwd_set(0, 0, 0, 0, 0, 0);
        id_idle();
`ifdef ID_EX_WB_BYPASS_EN
        expect_now(F_D1, 32'h99, "wb_bypass_capture");
`else
        expect_now(F_D1, 32'h1, "regfile_capture");
`endif
        tick();
        tick();

        if (sb.size() != 0) begin
            bad += sb.size();
            total += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
